adc_dual_serial_reader: RTL and testbench

Serial master for a dual-output SAR ADC: drives CS and SCK, shifts in the DOUTA and DOUTB bitstreams at the same time, and presents one parallel sample pair per conversion frame with a single-cycle valid strobe. It is the initiator end of the CS/SCK/DOUTA/DOUTB/RD_DONE link. The existing signal-generator model is the responder on that link. The block sits between the ADC pins (or that model) and the FIR filter datapath.

---
 rtl/adc_rd_pkg.sv | 18 +
 rtl/adc_shift_rx.sv | 22 ++
 rtl/adc_dual_serial_reader.sv | 171 +++++++++++++++++
 tb/tb_adc_dual_serial_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_rd_pkg.sv
// Shared types and defaults for the dual-channel ADC serial reader.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package adc_rd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        GAP
    } rd_state_t;

    localparam int DEF_DATA_W     = 12;
    localparam int DEF_FRAME_BITS = 16;
    localparam int CH_W           = 3;

endpackage

// File: rtl/adc_shift_rx.sv
// MSB-first serial-to-parallel shift register.
// Latency: one bit enters per clock that has sample_en set.
// Backpressure: none; the caller paces it with sample_en.
module adc_shift_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             din,
    output logic [WIDTH-1:0] dat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat <= '0;
        end else if (sample_en) begin
            dat <= {dat[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/adc_dual_serial_reader.sv
// Dual-output SAR ADC serial master: drives CS/SCK and captures DOUTA/DOUTB into one sample pair per frame.
// Latency: CLK_DIV + 2*CLK_DIV*FRAME_BITS cycles of CS low, results with RD_DONE on the first CS-high cycle.
// Backpressure: none; frames run back to back while en is high. ADC_TWOS_COMP_EN selects two's-complement output.
module adc_dual_serial_reader
    import adc_rd_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CONV_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              DOUTA,
    input  logic              DOUTB,
    output logic              CS,
    output logic              SCK,
    output logic [CH_W-1:0]   AD_A2_A0,
    output logic              RD_DONE,
    output logic [DATA_W-1:0] sample_a,
    output logic [DATA_W-1:0] sample_b,
    output logic [CH_W-1:0]   sample_ch
);

    localparam int CNT_MAX = (2 * CLK_DIV > CONV_GAP) ? 2 * CLK_DIV : CONV_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PER_M1   = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(CONV_GAP - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

`ifdef ADC_TWOS_COMP_EN
    localparam logic [DATA_W-1:0] MSB_FLIP = {1'b1, {(DATA_W-1){1'b0}}};
`else
    localparam logic [DATA_W-1:0] MSB_FLIP = '0;
`endif

    rd_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic             latch_ch;
    logic             sck_nxt;
    logic             sample_en;
    logic [FRAME_BITS-1:0] rx_a, rx_b;
    logic             unused_msbs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
        end
    end

    // cnt is shared: SETUP half-period, SHIFT phase within one SCK period, GAP length.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        latch_ch  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                    latch_ch  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == HALF_M1) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt == PER_M1) begin
                    cnt_nxt = '0;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = DONE;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = GAP;
                cnt_nxt   = '0;
            end
            GAP: begin
                if (cnt == GAP_M1) begin
                    cnt_nxt = '0;
                    if (en) begin
                        state_nxt = SETUP;
                        latch_ch  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SCK is low for the first half of each SHIFT period; data is taken on the edge that raises it.
    assign sck_nxt   = (state_nxt != SHIFT) || (cnt_nxt >= HALF);
    assign sample_en = (state == SHIFT) && (state_nxt == SHIFT) && (cnt_nxt == HALF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CS       <= 1'b1;
            SCK      <= 1'b1;
            RD_DONE  <= 1'b0;
            AD_A2_A0 <= '0;
        end else begin
            CS      <= !((state_nxt == SETUP) || (state_nxt == SHIFT));
            SCK     <= sck_nxt;
            RD_DONE <= (state_nxt == DONE);
            if (latch_ch) begin
                AD_A2_A0 <= ch_sel;
            end
        end
    end

    adc_shift_rx #(.WIDTH(FRAME_BITS)) u_rx_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .din       (DOUTA),
        .dat       (rx_a)
    );

    adc_shift_rx #(.WIDTH(FRAME_BITS)) u_rx_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .din       (DOUTB),
        .dat       (rx_b)
    );

    // Leading FRAME_BITS-DATA_W bits are conversion preamble and are dropped.
    assign unused_msbs = ^{rx_a, rx_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_a  <= '0;
            sample_b  <= '0;
            sample_ch <= '0;
        end else if (state_nxt == DONE) begin
            sample_a  <= rx_a[DATA_W-1:0] ^ MSB_FLIP;
            sample_b  <= rx_b[DATA_W-1:0] ^ MSB_FLIP;
            sample_ch <= AD_A2_A0;
        end
    end

endmodule

// File: tb/tb_adc_dual_serial_reader.sv
// Bench for adc_dual_serial_reader: ADC responder, frame-level model and directed scenarios.
module tb_adc_dual_serial_reader;

`ifdef ADC_TWOS_COMP_EN
    localparam bit TWOS = 1'b1;
`else
    localparam bit TWOS = 1'b0;
`endif
    localparam int DIV    = 2;
    localparam int FRAME  = 16;
    localparam int CS_LOW = DIV + 2 * DIV * FRAME;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic [2:0] ch_sel = 3'd0;
    logic douta = 1'b0;
    logic doutb = 1'b0;
    logic cs, sck, rd_done;
    logic [2:0] ad, sch;
    logic [11:0] sa, sb;

    logic en1 = 1'b0;
    logic [2:0] ch_sel1 = 3'd6;
    logic one = 1'b1;
    logic cs1, sck1, rd_done1;
    logic [2:0] ad1, sch1;
    logic [11:0] sa1, sb1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_dual_serial_reader dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_sel(ch_sel),
        .DOUTA(douta), .DOUTB(doutb), .CS(cs), .SCK(sck),
        .AD_A2_A0(ad), .RD_DONE(rd_done),
        .sample_a(sa), .sample_b(sb), .sample_ch(sch)
    );

    adc_dual_serial_reader #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .ch_sel(ch_sel1),
        .DOUTA(one), .DOUTB(one), .CS(cs1), .SCK(sck1),
        .AD_A2_A0(ad1), .RD_DONE(rd_done1),
        .sample_a(sa1), .sample_b(sb1), .sample_ch(sch1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Responder: a new 16-bit word per frame, launched MSB first on each SCK falling edge.
    logic [15:0] word_a = 16'h0, word_b = 16'h0, resp_a = 16'h0, resp_b = 16'h0;
    int idx = 0;
    always @(negedge cs) begin
        idx = 0;
        resp_a = word_a;
        resp_b = word_b;
    end
    always @(negedge sck) begin
        if (idx < 16) begin
            douta = resp_a[15 - idx];
            doutb = resp_b[15 - idx];
        end
        idx++;
    end

    function automatic logic [11:0] conv(input logic [15:0] w);
        logic [11:0] r;
        r = w[11:0];
        if (TWOS) r = r ^ 12'h800;
        return r;
    endfunction

    // Frame-level model and per-cycle comparison.
    int cyc = 0, cs_low = 0, cs_low_last = 0, rises = 0, last_rise = 0;
    logic in_frame = 1'b0, prev_cs = 1'b1, prev_sck = 1'b1, done_exp;
    logic [11:0] exp_a = '0, exp_b = '0;
    logic [2:0] exp_ch = '0, frame_ch = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            chk("rst_cs", cs, 1);
            chk("rst_sck", sck, 1);
            chk("rst_rd_done", rd_done, 0);
            chk("rst_ad", ad, 0);
            chk("rst_sample_a", sa, 0);
            chk("rst_sample_b", sb, 0);
            chk("rst_sample_ch", sch, 0);
            exp_a = '0; exp_b = '0; exp_ch = '0;
            in_frame = 1'b0; prev_cs = 1'b1; prev_sck = 1'b1;
        end else begin
            done_exp = in_frame && cs;
            if (done_exp) begin
                chk("cs_low_len", cs_low, CS_LOW);
                chk("sck_periods", rises, FRAME);
                cs_low_last = cs_low;
                exp_a = conv(resp_a);
                exp_b = conv(resp_b);
                exp_ch = frame_ch;
                in_frame = 1'b0;
            end
            if (prev_cs && !cs) begin
                in_frame = 1'b1;
                cs_low = 0;
                rises = 0;
                frame_ch = ch_sel;
            end
            if (!cs) begin
                cs_low++;
                chk("ad_frame", ad, frame_ch);
                if (sck && !prev_sck) begin
                    if (rises > 0) chk("sck_period", cyc - last_rise, 2 * DIV);
                    rises++;
                    last_rise = cyc;
                end
            end else begin
                chk("sck_idle_high", sck, 1);
            end
            chk("rd_done", rd_done, done_exp);
            chk("sample_a", sa, exp_a);
            chk("sample_b", sb, exp_b);
            chk("sample_ch", sch, exp_ch);
            prev_cs = cs;
            prev_sck = sck;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (rd_done) begin
                at = cyc;
                break;
            end
        end
        chk("rd_done_seen", at >= 0, 1);
    endtask

    task automatic wait_cs_low(input int budget);
        int seen;
        seen = 0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (!cs) begin
                seen = 1;
                break;
            end
        end
        chk("cs_low_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, n, lo1, ri1;
        logic p1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_cs", cs, 1);
        chk("reset_sck", sck, 1);
        chk("reset_sample_a", sa, 0);
        rst_n = 1'b1;
        tick();

        // Single frame, channel 3.
        word_a = 16'h5ABC; word_b = 16'hA123;
        ch_sel = 3'd3; en = 1'b1;
        wait_done(200, t0);
        chk("t1_sample_a", sa, TWOS ? 12'h2BC : 12'hABC);
        chk("t1_sample_b", sb, TWOS ? 12'h923 : 12'h123);
        chk("t1_sample_ch", sch, 3);
        chk("t1_ad", ad, 3);
        chk("t1_cs_low", cs_low_last, 66);
        en = 1'b0;
        repeat (20) tick();
        chk("t1_idle_cs", cs, 1);

        // Three back-to-back frames, ch_sel changes mid-frame 1.
        word_a = 16'h3456; word_b = 16'hC789;
        ch_sel = 3'd1; en = 1'b1;
        wait_cs_low(50);
        repeat (30) tick();
        ch_sel = 3'd5;
        wait_done(200, t1);
        chk("t2_f1_ch", sch, 1);
        chk("t2_f1_sample_a", sa, TWOS ? 12'hC56 : 12'h456);
        wait_done(200, t2);
        chk("t2_f2_ch", sch, 5);
        chk("t2_period_12", t2 - t1, 71);
        wait_done(200, t3);
        chk("t2_period_23", t3 - t2, 71);
        en = 1'b0;
        repeat (20) tick();

        // en dropped at cycle 20: frame completes, then stays idle.
        word_a = 16'h1800; word_b = 16'hE7FF;
        en = 1'b1;
        wait_cs_low(50);
        repeat (20) tick();
        en = 1'b0;
        wait_done(200, t0);
        chk("t3_sample_b", sb, TWOS ? 12'hFFF : 12'h7FF);
        n = 0;
        repeat (40) begin
            tick();
            if (!cs || !sck) n++;
        end
        chk("t3_no_activity", n, 0);

        // Reset at cycle 40 of a frame, then a fresh frame.
        word_a = 16'h75A5; word_b = 16'h80F0;
        ch_sel = 3'd2; en = 1'b1;
        wait_cs_low(50);
        repeat (40) tick();
        rst_n = 1'b0;
        #1;
        chk("t4_cs", cs, 1);
        chk("t4_sck", sck, 1);
        chk("t4_sample_a", sa, 0);
        chk("t4_sample_b", sb, 0);
        chk("t4_sample_ch", sch, 0);
        chk("t4_rd_done", rd_done, 0);
        tick();
        rst_n = 1'b1;
        wait_done(200, t0);
        chk("t4_fresh_sample_a", sa, TWOS ? 12'hDA5 : 12'h5A5);
        chk("t4_fresh_sample_b", sb, TWOS ? 12'h8F0 : 12'h0F0);
        chk("t4_fresh_ch", sch, 2);
        chk("t4_fresh_cs_low", cs_low_last, 66);
        en = 1'b0;
        repeat (10) tick();

        // CLK_DIV=1 instance with DOUT held high.
        en1 = 1'b1;
        lo1 = 0; ri1 = 0; p1 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!cs1) begin
                lo1++;
                if (sck1 && !p1) ri1++;
            end
            p1 = sck1;
            if (rd_done1) break;
        end
        chk("t5_rd_done", rd_done1, 1);
        chk("t5_cs_low", lo1, 33);
        chk("t5_sck_rises", ri1, 16);
        chk("t5_sample_a", sa1, TWOS ? 12'h7FF : 12'hFFF);
        chk("t5_sample_b", sb1, TWOS ? 12'h7FF : 12'hFFF);
        chk("t5_sample_ch", sch1, 6);
        chk("t5_ad", ad1, 6);
        en1 = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
